// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M/RV64M multiply/divide execution unit. Radix-2
//            shift-add multiply and restoring divide, one bit per cycle,
//            with sign handled by magnitude/sign-flag decomposition.
// Ports    : clk      - rising-edge clock
//            reset_n  - asynchronous active-low reset
//            start    - request, accepted only while busy=0
//            func3    - operation select (MUL..REMU), sampled on accept
//            rs1/rs2  - operands A/B, sampled on accept
//            flush    - abort the operation in flight
//            busy     - operation in flight (EX stall)
//            done     - one-cycle pulse, result updated this cycle
//            result   - registered result, held until the next done
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W  = $clog2(XLEN);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  C_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]  r_count;
  logic [2:0]        r_op;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic              r_special;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [XLEN-1:0]   r_opnd;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*XLEN-1:0] r_acc;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  // ---------------- accept-time decode ----------------
  logic            w_accept;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_val;

  assign w_accept   = start && (r_state == S_IDLE) && !flush;
  // Unsigned A only for MULHU/DIVU/REMU; B is additionally unsigned for MULHSU.
  assign w_a_signed = ~(func3[0] & (func3[1] | func3[2]));
  assign w_b_signed = w_a_signed & (func3 != 3'b010);
  assign w_a_neg    = w_a_signed & rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -rs1 : rs1;
  assign w_b_mag    = w_b_neg ? -rs2 : rs2;

  assign w_div0     = func3[2] && (rs2 == '0);
  assign w_ovf      = func3[2] && !func3[0] && (rs1 == C_MIN) && (rs2 == '1);
  assign w_special  = w_div0 | w_ovf;
  assign w_spec_val = w_div0 ? (func3[1] ? rs1 : '1)
                             : (func3[1] ? '0  : rs1);

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]     w_div_sh;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_div_nxt;

  // Add multiplicand into the upper half when the current multiplier bit is
  // set; the carry is kept and the whole accumulator shifts right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt  = {w_mul_sum, r_acc[XLEN-1:1]};

  // Shift the next dividend bit into the remainder and trial-subtract; a
  // negative difference restores the shifted remainder.
  assign w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_opnd};
  assign w_div_nxt  = w_div_diff[XLEN]
                    ? {w_div_sh[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0}
                    : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  // ---------------- final sign correction / selection ----------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    if (r_special) begin
      w_fix_res = r_acc[XLEN-1:0];
    end else begin
      case (r_op)
        3'b000:                 w_fix_res = w_prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         w_fix_res = w_quo;
        default:                w_fix_res = w_rem;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_FIX : S_CALC;
      S_CALC: begin
        if (flush)                  w_state_nxt = S_IDLE;
        else if (r_count == C_LAST) w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_op      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_special <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op      <= func3;
        r_neg_res <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_count   <= '0;
        r_special <= w_special;
        if (w_special) begin
          r_opnd <= '0;
          r_acc  <= {{XLEN{1'b0}}, w_spec_val};
        end else if (func3[2]) begin
          r_opnd <= w_b_mag;
          r_acc  <= {{XLEN{1'b0}}, w_a_mag};
        end else begin
          r_opnd <= w_a_mag;
          r_acc  <= {{XLEN{1'b0}}, w_b_mag};
        end
      end else if ((r_state == S_CALC) && !flush) begin
        r_count <= r_count + CNT_W'(1);
        r_acc   <= r_op[2] ? w_div_nxt : w_mul_nxt;
      end else if ((r_state == S_FIX) && !flush) begin
        r_result <= w_fix_res;
        r_done   <= 1'b1;
      end
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed testbench for muldiv_unit (XLEN=32). Expected results
//            are pushed to a scoreboard queue at issue and popped on done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic            start   = 1'b0;
  logic [2:0]      func3   = '0;
  logic [XLEN-1:0] rs1     = '0;
  logic [XLEN-1:0] rs2     = '0;
  logic            flush   = 1'b0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .func3   (func3),
    .rs1     (rs1),
    .rs2     (rs2),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  int              n_vec = 0;
  int              n_err = 0;
  logic [31:0]     sb_q[$];
  logic [31:0]     last_res = '0;
  logic [2:0]      rf;
  logic [31:0]     ra;
  logic [31:0]     rb;
  int              rl;
  int              dcnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference built on native wide/signed arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic        [63:0] ua, ub, up;
    logic signed [31:0] a32, b32, r32;
    logic               ovf;
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    a32 = a;
    b32 = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = ua * ub;           return up[31:0];  end
      3'd1: begin sp = sa * sb;           return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub);  return sp[63:32]; end
      3'd3: begin up = ua * ub;           return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        r32 = a32 / b32;
        return r32;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        r32 = a32 % b32;
        return r32;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called #1 after an edge. Drives one request, lets it be accepted, then
  // scrambles the inputs so any re-sampling would corrupt the result.
  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push);
    func3 = f;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    if (push) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    func3 = 3'($urandom);
    rs1   = $urandom;
    rs2   = $urandom;
    check({tag, " accept busy"}, busy, 1'b1);
    check({tag, " accept done"}, done, 1'b0);
  endtask

  // Called #1 after the accept edge; returns #1 after the done edge.
  // poke>0 injects a stray start at that cycle of the operation.
  task automatic wait_done(input string tag, input int lat, input int poke);
    int   k;
    int   bcnt;
    int   hold_bad;
    bit   seen;
    logic [31:0] exp;
    k        = 0;
    bcnt     = 1;
    hold_bad = 0;
    seen     = 1'b0;
    while (k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (poke > 0 && k == poke) begin
        start = 1'b1;
        func3 = 3'b000;
        rs1   = 32'd3;
        rs2   = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (result !== last_res) hold_bad++;
    end
    check({tag, " latency"}, k, lat);
    check({tag, " busy cycles"}, bcnt, lat);
    check({tag, " busy at done"}, busy, 1'b0);
    check({tag, " result held"}, hold_bad, 0);
    if (seen) begin
      check({tag, " scoreboard nonempty"}, sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check({tag, " result"}, result, exp);
        last_res = exp;
      end
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- multiplies ----------------
    issue("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    wait_done("MUL", 33, 0);
    issue("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    wait_done("MULH", 33, 0);
    issue("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    wait_done("MULHU", 33, 0);
    issue("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("MULHSU", 33, 0);

    // ---------------- divides, back-to-back from the done cycle ----------------
    issue("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    wait_done("DIV", 33, 0);
    issue("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    wait_done("REM", 33, 0);
    issue("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_done("DIVU", 33, 0);
    issue("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 1'b1);
    wait_done("REMU", 33, 0);

    // ---------------- special cases ----------------
    issue("DIV0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_done("DIV0", 1, 0);
    issue("DIVU0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_done("DIVU0", 1, 0);
    issue("REM0", 3'b110, 32'd5, 32'd0, 32'd5, 1'b1);
    wait_done("REM0", 1, 0);
    issue("REMU0", 3'b111, 32'd5, 32'd0, 32'd5, 1'b1);
    wait_done("REMU0", 1, 0);
    issue("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    wait_done("DIVOVF", 1, 0);
    issue("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    wait_done("REMOVF", 1, 0);

    // ---------------- random operations against the reference ----------------
    for (int i = 0; i < 8; i++) begin
      rf = 3'(i);
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = 32'h8000_0000 | rb;
      if (rb == 0) rb = 32'd1;
      rl = (rf[2] && !rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ? 1 : 33;
      issue("RND", rf, ra, rb, ref_op(rf, ra, rb), 1'b1);
      wait_done("RND", rl, 0);
    end

    // ---------------- flush on the 10th CALC cycle ----------------
    issue("FLUSH", 3'b000, 32'h1234, 32'h5678, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy", busy, 1'b0);
    check("flush done", done, 1'b0);
    check("flush result", result, last_res);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("flush no late done", dcnt, 0);

    // flush in IDLE blocks a same-cycle start
    start = 1'b1;
    flush = 1'b1;
    func3 = 3'b000;
    rs1   = 32'd2;
    rs2   = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("idle flush blocks start", busy, 1'b0);

    // ---------------- stray start mid-operation ----------------
    issue("IGN", 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_done("IGN", 33, 6);

    // ---------------- async reset mid-CALC ----------------
    issue("RST", 3'b000, 32'd9, 32'd9, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset done", done, 1'b0);
    check("async reset result", result, 32'd0);
    last_res = '0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue("MUL34", 3'b000, 32'd3, 32'd4, 32'd12, 1'b1);
    wait_done("MUL34", 33, 0);

    check("scoreboard drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
